serial_adder: RTL and testbench

Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per clock, using a single full-adder cell and a carry flip-flop. It is the sequential, width-generic successor of the team's combinational 1-bit adder cells. It is intended for area-constrained datapaths where a multi-cycle add is acceptable. It exposes a start/busy/done handshake and holds its result until the next operation completes.

---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/full_adder_cell.sv | 11 +
 rtl/serial_adder.sv | 72 +++++++
 tb/tb_serial_adder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and width limits for bit-serial arithmetic
package serial_arith_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;
  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add one bit per clock through a single full-adder cell
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sr_a, sr_b, res, res_nxt;
  logic            carry, fa_s, fa_co, accept, last;
  full_adder_cell u_fa (
    .a (sr_a[0]),
    .b (sr_b[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );
  always_comb begin
    accept    = start && (state == IDLE || state == FIN);
    last      = cnt == CW'(WIDTH - 1);
    res_nxt   = WIDTH'({fa_s, res} >> 1);
    state_nxt = accept ? RUN : state == RUN ? (last ? FIN : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == FIN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sr_a  <= '0;
      sr_b  <= '0;
      res   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sr_a  <= a;
        sr_b  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        sr_a  <= sr_a >> 1;
        sr_b  <= sr_b >> 1;
        res   <= res_nxt;
        carry <= fa_co;
        cnt   <= cnt + CW'(1);
        // outputs move only on the final bit so S/COUT hold steady during RUN
        if (last) begin
          s    <= res_nxt;
          cout <= fa_co;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b1, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] s;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       busy1, done1, s1, cout1;
  int         total = 0, passed = 0;
  logic [7:0] exp_s = 8'h00;
  logic [1:0] sum1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout)
  );
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      input logic [7:0] es, input logic ec);
    int  n;
    logic stable;
    a = va; b = vb; cin = vc; start = 1'b1;
    step();
    start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
    chk("busy_after_accept", busy, 1'b1);
    n = 0;
    stable = 1'b1;
    while (!done && n < 20) begin
      step();
      n++;
      if (!done && s !== exp_s) stable = 1'b0;
    end
    chk("latency", n, 8);
    chk("s_stable_in_run", stable, 1'b1);
    chk("sum", s, es);
    chk("cout", cout, ec);
    chk("busy_at_done", busy, 1'b0);
    exp_s = es;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_s", s, 8'h00);
      chk("rst_cout", cout, 1'b0);
    end
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle_busy", busy, 1'b0);

    add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    step();
    chk("done_one_cycle", done, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // START held: accepts at k=0,9,18 with a=0x10+k, b=0x20
    for (int k = 0; k < 27; k++) begin
      a = 8'h10 + 8'(k); b = 8'h20; cin = 1'b0; start = 1'b1;
      step();
      chk("pipe_done", done, k % 9 == 8);
      if (k % 9 == 8) exp_s = 8'h30 + 8'(k - 8);
      chk("pipe_s", s, exp_s);
    end
    start = 1'b0;
    for (int n = 0; n < 12 && !done; n++) step();
    chk("pipe_drain", done, 1'b1);
    chk("pipe_last_s", s, 8'h42);

    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_s", s, 8'h00);
    chk("abort_cout", cout, 1'b0);
    chk("abort_busy", busy, 1'b0);
    begin
      logic seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
        step();
        if (done) seen = 1'b1;
      end
      chk("abort_no_done", seen, 1'b0);
    end
    exp_s = 8'h00;
    add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    for (int v = 0; v < 8; v++) begin
      {a1, b1, cin1} = 3'(v);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1'b1);
      step();
      chk("w1_done", done1, 1'b1);
      chk("w1_sum", {cout1, s1}, sum1[v]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
